// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared definitions for the bit-serial subtractor.
//   state_e       - FSM state encoding (IDLE / SHIFT / DONE, 2 bits)
//   DEFAULT_WIDTH - default operand/result width
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_fa.sv
// full_adder_1bit: single combinational full-adder slice.
//   a, b, cin -> sum, cout
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, a - b = a + ~b + 1,
// one bit per clock LSB first through a single full-adder slice.
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - operand handshake (a, b)
//   out_valid/out_ready  - result handshake (diff, carryout, overflow)
// Result appears WIDTH cycles after the accepting edge and holds until drained.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             carryout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic fa_sum, fa_cout;

  full_adder_1bit u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = ~b;
          carry_d = 1'b1;   // the +1 of two's-complement negation
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // MSB slice: carry_q is the carry into the MSB, so overflow is
          // resolved here instead of keeping a separate carry-in register.
          diff_d  = {fa_sum, res_q[WIDTH-1:1]};
          co_d    = fa_cout;
          ov_d    = carry_q ^ fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign carryout  = co_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carryout, overflow;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .carryout  (carryout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    exp_t       e;
    s      = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    e.a    = x;
    e.b    = y;
    e.diff = s[W-1:0];
    e.co   = s[W];
    e.ov   = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    return e;
  endfunction

  // Called just after a negedge with the DUT idle. Drives one operation,
  // holds the result for bp cycles, drains it, returns just after a negedge.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input int bp);
    exp_t e;
    int   lat;
    chk("in_ready_idle", in_ready, 1);
    a = x; b = y; in_valid = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);               // accepting edge has passed
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 3*W) begin
      chk("no_early_valid", out_valid, 0);
      in_valid  = 1'($urandom_range(0, 1));  // ignored outside IDLE
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, W);
    e = sb.pop_front();
    repeat (bp) begin
      out_ready = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_diff", diff, e.diff);
      chk("hold_carryout", carryout, e.co);
      chk("hold_overflow", overflow, e.ov);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("out_valid", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    chk("diff", diff, e.diff);
    chk("carryout", carryout, e.co);
    chk("overflow", overflow, e.ov);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drained_valid", out_valid, 0);
    chk("drained_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_carryout", carryout, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'b0100, 4'b0100, 0);   // 4-4
    do_op(4'b0011, 4'b0101, 1);   // 3-5
    do_op(4'b0111, 4'b1111, 0);   // 7-(-1)
    do_op(4'b1000, 4'b0001, 5);   // -8-1 under backpressure

    // reset in the middle of SHIFT discards the partial result
    chk("pre_abort_in_ready", in_ready, 1);
    a = 4'b0110; b = 4'b0001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_diff", diff, 0);
    chk("abort_carryout", carryout, 0);
    chk("abort_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      chk("post_abort_no_valid", out_valid, 0);
    end
    do_op(4'b0110, 4'b0001, 0);

    for (int i = 0; i < (1 << W); i++)
      for (int j = 0; j < (1 << W); j++)
        do_op(W'(i), W'(j), int'($urandom_range(0, 2)));

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
